// File: rtl/note_sequencer.sv
// Step sequencer for the synth voice: plays up to STEPS programmed notes, pulsing
// trig for a gate time per step, with all timing counted in tick strobes.
module note_sequencer #(
    parameter int STEPS  = 8,
    parameter int CNT_W  = 12,
    parameter int TIME_W = 16,
    localparam int AW    = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              tick,
    input  logic              run,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CNT_W-1:0]  wr_note,
    input  logic              wr_rest,
    input  logic [AW-1:0]     len,
    input  logic [TIME_W-1:0] tempo,
    input  logic [TIME_W-1:0] gate,
    output logic [CNT_W-1:0]  osc_count,
    output logic              trig,
    output logic [AW-1:0]     step,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GATE = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [TIME_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]     step_q, step_d;
    logic [CNT_W-1:0]  osc_q, osc_d;
    logic              trig_q, trig_d;

    logic [CNT_W-1:0]  note_q [STEPS];
    logic              rest_q [STEPS];

    logic [TIME_W-1:0] tempo_eff;
    logic [TIME_W-1:0] tempo_last;
    logic [TIME_W-1:0] geff;
    logic [AW-1:0]     next_step;
    logic [AW-1:0]     load_step;
    logic              load_rest;
    logic [CNT_W-1:0]  load_note;
    logic              load_gate;
    logic              step_end;
    logic              gate_end;

    // Gate is clamped so trig always falls at least one tick before the next step.
    assign tempo_eff  = (tempo == '0) ? {{(TIME_W-1){1'b0}}, 1'b1} : tempo;
    assign tempo_last = tempo_eff - 1'b1;
    assign geff       = (gate < tempo_last) ? gate : tempo_last;

    assign next_step = (step_q >= len) ? '0 : step_q + 1'b1;
    assign load_step = (state_q == ST_IDLE) ? '0 : next_step;
    assign load_rest = rest_q[load_step];
    assign load_note = note_q[load_step];
    assign load_gate = !load_rest && (geff != '0);

    assign step_end = tick && (cnt_q >= tempo_last);
    assign gate_end = tick && (({1'b0, cnt_q} + 1'b1) >= {1'b0, geff});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        osc_d   = osc_q;
        trig_d  = trig_q;

        if (!run) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            step_d  = '0;
            trig_d  = 1'b0;
        end else if ((state_q == ST_IDLE) || step_end) begin
            cnt_d   = '0;
            step_d  = load_step;
            state_d = load_gate ? ST_GATE : ST_HOLD;
            trig_d  = load_gate;
            if (!load_rest) begin
                osc_d = load_note;
            end
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
            if ((state_q == ST_GATE) && gate_end) begin
                state_d = ST_HOLD;
                trig_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            osc_q   <= '0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            osc_q   <= osc_d;
            trig_q  <= trig_d;
        end
    end

    // A load on the same edge as a write to that entry still sees the old contents.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < STEPS; i++) begin
                note_q[i] <= '0;
                rest_q[i] <= 1'b1;
            end
        end else if (wr_en) begin
            note_q[wr_addr] <= wr_note;
            rest_q[wr_addr] <= wr_rest;
        end
    end

    assign osc_count = osc_q;
    assign trig      = trig_q;
    assign step      = step_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed scenarios plus randomized play,
// compared every cycle against a position-within-step reference model.
module tb_note_sequencer;

    logic        clk;
    logic        rstn;
    logic        tick;
    logic        run;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [11:0] wr_note;
    logic        wr_rest;
    logic [2:0]  len;
    logic [15:0] tempo;
    logic [15:0] gate;
    logic [11:0] osc_count;
    logic        trig;
    logic [2:0]  step;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int          mNote [8];
    bit          mRest [8];
    logic [11:0] mOsc;
    logic        mTrig;
    int          mStep;
    int          mPos;
    bit          mPlay;
    bit          mCurRest;

    note_sequencer #(.STEPS(8), .CNT_W(12), .TIME_W(16)) dut (
        .clk(clk), .rstn(rstn), .tick(tick), .run(run),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note), .wr_rest(wr_rest),
        .len(len), .tempo(tempo), .gate(gate),
        .osc_count(osc_count), .trig(trig), .step(step), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic modelReset();
        for (int i = 0; i < 8; i++) begin
            mNote[i] = 0;
            mRest[i] = 1'b1;
        end
        mOsc = '0; mTrig = 1'b0; mStep = 0; mPos = 0; mPlay = 1'b0; mCurRest = 1'b1;
    endtask

    task automatic loadEntry(input int s);
        mCurRest = mRest[s];
        if (!mRest[s]) mOsc = 12'(mNote[s]);
    endtask

    // Trig is simply "playing a non-rest step and still inside its gate window".
    task automatic modelStep();
        int te, ge;
        te = (tempo == 0) ? 1 : int'(tempo);
        ge = (int'(gate) < te - 1) ? int'(gate) : te - 1;
        if (!run) begin
            mPlay = 1'b0; mStep = 0; mPos = 0;
        end else if (!mPlay) begin
            mPlay = 1'b1; mStep = 0; mPos = 0;
            loadEntry(0);
        end else if (tick) begin
            if (mPos >= te - 1) begin
                mPos = 0;
                mStep = (mStep >= int'(len)) ? 0 : mStep + 1;
                loadEntry(mStep);
            end else begin
                mPos++;
            end
        end
        if (wr_en) begin
            mNote[wr_addr] = int'(wr_note);
            mRest[wr_addr] = wr_rest;
        end
        mTrig = mPlay && !mCurRest && (mPos < ge);
    endtask

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (osc_count === mOsc) else begin
            errors++;
            $error("FAIL %s osc_count observed %0d expected %0d", tag, osc_count, mOsc);
        end
        checks++;
        assert (trig === mTrig) else begin
            errors++;
            $error("FAIL %s trig observed %0b expected %0b", tag, trig, mTrig);
        end
        checks++;
        assert (step === 3'(mStep)) else begin
            errors++;
            $error("FAIL %s step observed %0d expected %0d", tag, step, mStep);
        end
        checks++;
        assert (busy === mPlay) else begin
            errors++;
            $error("FAIL %s busy observed %0b expected %0b", tag, busy, mPlay);
        end
    endtask

    task automatic applyStimulus(input string tag);
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
        wr_en = 1'b0;
    endtask

    task automatic writeEntry(input int a, input int n, input bit r);
        wr_en = 1'b1; wr_addr = 3'(a); wr_note = 12'(n); wr_rest = r;
        applyStimulus("write");
    endtask

    initial begin
        int highs;
        rstn = 1'b0; tick = 1'b1; run = 1'b0; wr_en = 1'b0; wr_addr = '0;
        wr_note = '0; wr_rest = 1'b0; len = 3'd2; tempo = 16'd4; gate = 16'd2;
        modelReset();
        #3;
        checkOutput("reset");
        @(posedge clk);
        #1 rstn = 1'b1;

        writeEntry(0, 100, 0);
        writeEntry(1, 200, 0);
        writeEntry(2, 300, 0);

        run = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            applyStimulus("basic");
            if (i == 1)  checkEq("basic_osc_s0", osc_count, 100);
            if (i == 2)  checkEq("basic_trig_hi", trig, 1);
            if (i == 3)  checkEq("basic_trig_lo", trig, 0);
            if (i == 5)  checkEq("basic_osc_s1", osc_count, 200);
            if (i == 9)  checkEq("basic_osc_s2", osc_count, 300);
            if (i == 13) checkEq("basic_osc_wrap", osc_count, 100);
        end

        rstn = 1'b0;
        #1;
        modelReset();
        checkOutput("reset_mid_gate");
        checkEq("reset_trig", trig, 0);
        #2 rstn = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus("all_rests");
        checkEq("all_rests_osc", osc_count, 0);

        run = 1'b0;
        writeEntry(0, 100, 0);
        writeEntry(1, 200, 0);
        writeEntry(2, 300, 0);
        tempo = 16'd3; gate = 16'd10;
        run = 1'b1;
        highs = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus("gate_clamp");
            highs += int'(trig);
        end
        checkEq("gate_clamp_highs", highs, 6);

        run = 1'b0;
        applyStimulus("stop");
        gate = 16'd0;
        run = 1'b1;
        highs = 0;
        for (int i = 1; i <= 9; i++) begin
            applyStimulus("gate_zero");
            highs += int'(trig);
            if (i == 4) checkEq("gate_zero_osc", osc_count, 200);
        end
        checkEq("gate_zero_highs", highs, 0);

        run = 1'b0;
        tempo = 16'd4; gate = 16'd2;
        writeEntry(1, 777, 1);
        run = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus("rest");
            if (i == 5) begin
                checkEq("rest_trig", trig, 0);
                checkEq("rest_osc_hold", osc_count, 100);
            end
        end
        run = 1'b0;
        applyStimulus("stop_mid");
        checkEq("stop_busy", busy, 0);
        checkEq("stop_step", step, 0);
        checkEq("stop_osc_hold", osc_count, 300);

        writeEntry(1, 200, 0);
        run = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            if (i == 6) begin
                wr_en = 1'b1; wr_addr = 3'd1; wr_note = 12'd555; wr_rest = 1'b0;
            end
            applyStimulus("live_edit");
            if (i == 1) checkEq("restart_osc", osc_count, 100);
            if (i == 8) checkEq("live_edit_now", osc_count, 200);
            if (i == 17) checkEq("live_edit_next", osc_count, 555);
        end

        run = 1'b0;
        applyStimulus("stop");
        tempo = 16'd0;
        run = 1'b1;
        for (int i = 1; i <= 4; i++) applyStimulus("tempo_zero");
        checkEq("tempo_zero_step", step, 0);

        for (int ep = 0; ep < 40; ep++) begin
            run = 1'b0;
            tempo = 16'($urandom_range(0, 6));
            gate  = 16'($urandom_range(0, 7));
            len   = 3'($urandom_range(0, 7));
            applyStimulus("rand_stop");
            run = 1'b1;
            for (int c = 0; c < int'($urandom_range(5, 30)); c++) begin
                tick = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) == 0) begin
                    wr_en = 1'b1;
                    wr_addr = 3'($urandom_range(0, 7));
                    wr_note = 12'($urandom_range(0, 4095));
                    wr_rest = ($urandom_range(0, 3) == 0);
                end
                if ($urandom_range(0, 19) == 0) len = 3'($urandom_range(0, 7));
                applyStimulus("random");
            end
            tick = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
